// File: rtl/ntsc_enc_comp.sv
// Composite NTSC encoder back end: mixes luma, 4fsc-modulated chroma, colour burst
// and sync into one clamped video code through a three-stage pipeline.
module ntsc_enc_comp #(
    parameter int               C_YW        = 8,
    parameter int               C_DW        = 10,
    parameter logic [15:0]      C_YGAIN     = 16'h028C,
    parameter logic [15:0]      C_CGAIN     = 16'h0100,
    parameter logic [C_DW-1:0]  C_PEDESTAL  = 'h0F0,
    parameter logic [C_DW-1:0]  C_SYNC_L    = 'h010,
    parameter logic [C_DW-1:0]  C_BURST_AMP = 'h038,
    parameter bit               C_CHROMA_EN = 1'b1
) (
    input  logic            CK_i,
    input  logic            AR_i,
    input  logic            CK_EE_i,
    input  logic [C_YW-1:0] YYs_i,
    input  logic [C_YW-1:0] UUs_i,
    input  logic [C_YW-1:0] VVs_i,
    input  logic            BURST_i,
    input  logic            BLANK_i,
    input  logic            XSYNC_i,
    input  logic            SC_RST_i,
    input  logic            CLR_i,
    output logic [C_DW-1:0] VIDEOs_o,
    output logic [1:0]      PHASEs_o,
    output logic            OVF_o
);
    localparam int SW  = C_DW + 3;
    localparam int CW  = C_YW + 1;
    localparam int YPW = C_YW + 16;
    localparam int CPW = CW + 17;

    localparam logic signed [CW-1:0] BAMP  = CW'(C_BURST_AMP);
    localparam logic signed [SW-1:0] PED_S = SW'(C_PEDESTAL);
    localparam logic signed [SW-1:0] VMAX  = SW'({C_DW{1'b1}});

    function automatic logic is_clamp(input logic signed [SW-1:0] s);
        return (s < 0) || (s > VMAX);
    endfunction

    function automatic logic [C_DW-1:0] sat_video(input logic signed [SW-1:0] s);
        if (s < 0)
            return '0;
        else if (s > VMAX)
            return '1;
        else
            return s[C_DW-1:0];
    endfunction

    logic [1:0]             phase_q, phase_d;
    logic [C_YW-1:0]        y_p1_q, y_p1_d;
    logic signed [CW-1:0]   c_p1_q, c_p1_d;
    logic                   xsync_p1_q, xsync_p1_d, blank_p1_q, blank_p1_d, burst_p1_q, burst_p1_d;
    logic signed [SW-1:0]   ys_p2_q, ys_p2_d, cs_p2_q, cs_p2_d;
    logic                   xsync_p2_q, xsync_p2_d, blank_p2_q, blank_p2_d, burst_p2_q, burst_p2_d;
    logic [C_DW-1:0]        video_q, video_d;
    logic                   ovf_q, ovf_d;

    logic signed [CW-1:0]   u_ext, v_ext, chroma_sel;
    logic [YPW-1:0]         yprod;
    logic signed [CPW-1:0]  cprod, cshift;
    logic signed [SW-1:0]   sum3;
    logic                   clamp_evt;

    assign u_ext = {UUs_i[C_YW-1], UUs_i};
    assign v_ext = {VVs_i[C_YW-1], VVs_i};

    always_comb begin
        phase_d = phase_q;
        if (SC_RST_i)
            phase_d = '0;
        else if (CK_EE_i)
            phase_d = phase_q + 2'd1;
    end

    // Stage 1: subcarrier modulation by sample index, or burst reference
    always_comb begin
        chroma_sel = '0;
        if (BURST_i) begin
            case (phase_q)
                2'd0:    chroma_sel = -BAMP;
                2'd2:    chroma_sel = BAMP;
                default: chroma_sel = '0;
            endcase
        end else begin
            case (phase_q)
                2'd0:    chroma_sel = u_ext;
                2'd1:    chroma_sel = v_ext;
                2'd2:    chroma_sel = -u_ext;
                default: chroma_sel = -v_ext;
            endcase
        end
        if (!C_CHROMA_EN)
            chroma_sel = '0;
    end

    // Stage 2: gain scaling; burst bypasses the chroma gain
    assign yprod  = {{C_YW{1'b0}}, C_YGAIN} * {16'd0, y_p1_q};
    assign cprod  = $signed({{(CPW-16){1'b0}}, C_CGAIN}) *
                    $signed({{(CPW-CW){c_p1_q[CW-1]}}, c_p1_q});
    assign cshift = cprod >>> 8;

    // Stage 3: sync/blank priority mix with clamp to the code range
    always_comb begin
        if (blank_p2_q) begin
            sum3 = PED_S;
            if (burst_p2_q)
                sum3 = PED_S + cs_p2_q;
        end else begin
            sum3 = PED_S + ys_p2_q + cs_p2_q;
        end
        clamp_evt = xsync_p2_q && is_clamp(sum3);
    end

    always_comb begin
        y_p1_d     = y_p1_q;
        c_p1_d     = c_p1_q;
        xsync_p1_d = xsync_p1_q;
        blank_p1_d = blank_p1_q;
        burst_p1_d = burst_p1_q;
        ys_p2_d    = ys_p2_q;
        cs_p2_d    = cs_p2_q;
        xsync_p2_d = xsync_p2_q;
        blank_p2_d = blank_p2_q;
        burst_p2_d = burst_p2_q;
        video_d    = video_q;
        if (CK_EE_i) begin
            y_p1_d     = YYs_i;
            c_p1_d     = chroma_sel;
            xsync_p1_d = XSYNC_i;
            blank_p1_d = BLANK_i;
            burst_p1_d = BURST_i;
            ys_p2_d    = {1'b0, yprod[8 +: SW-1]};
            cs_p2_d    = burst_p1_q ? {{(SW-CW){c_p1_q[CW-1]}}, c_p1_q} : cshift[SW-1:0];
            xsync_p2_d = xsync_p1_q;
            blank_p2_d = blank_p1_q;
            burst_p2_d = burst_p1_q;
            video_d    = xsync_p2_q ? sat_video(sum3) : C_SYNC_L;
        end
        // A clamp in the same cycle as a clear wins so no overflow is lost
        ovf_d = CLR_i ? 1'b0 : ovf_q;
        if (CK_EE_i && clamp_evt)
            ovf_d = 1'b1;
    end

    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            phase_q    <= '0;
            y_p1_q     <= '0;
            c_p1_q     <= '0;
            xsync_p1_q <= 1'b1;
            blank_p1_q <= 1'b1;
            burst_p1_q <= 1'b0;
            ys_p2_q    <= '0;
            cs_p2_q    <= '0;
            xsync_p2_q <= 1'b1;
            blank_p2_q <= 1'b1;
            burst_p2_q <= 1'b0;
            video_q    <= C_PEDESTAL;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            y_p1_q     <= y_p1_d;
            c_p1_q     <= c_p1_d;
            xsync_p1_q <= xsync_p1_d;
            blank_p1_q <= blank_p1_d;
            burst_p1_q <= burst_p1_d;
            ys_p2_q    <= ys_p2_d;
            cs_p2_q    <= cs_p2_d;
            xsync_p2_q <= xsync_p2_d;
            blank_p2_q <= blank_p2_d;
            burst_p2_q <= burst_p2_d;
            video_q    <= video_d;
            ovf_q      <= ovf_d;
        end
    end

    assign VIDEOs_o = video_q;
    assign PHASEs_o = phase_q;
    assign OVF_o    = ovf_q;

endmodule

// File: doc/ntsc_enc_comp.md
NTSC_ENC_COMP -- requirements
Module: ntsc_enc_comp

Interface
REQ-001 Parameter C_YW, default 8: width of YYs_i, UUs_i and VVs_i.
REQ-002 Parameter C_DW, default 10: width of VIDEOs_o.
REQ-003 Parameter C_YGAIN, default 16'h028C: luma gain, Q8.8 (value/256).
REQ-004 Parameter C_CGAIN, default 16'h0100: chroma gain, Q8.8.
REQ-005 Parameter C_PEDESTAL, default 10'h0F0: blank/black level code.
REQ-006 Parameter C_SYNC_L, default 10'h010: sync tip code.
REQ-007 Parameter C_BURST_AMP, default 10'h038: burst peak deviation from pedestal.
REQ-008 Parameter C_CHROMA_EN, default 1: 0 = luma-only mode; chroma and burst are forced to 0.
REQ-009 CK_i  in  1  sole clock; all state updates on the rising edge.
REQ-010 AR_i  in  1  reset, asynchronous and active-high.
REQ-011 CK_EE_i  in  1  clock enable; the pipeline and phase counter advance only when it is 1.
REQ-012 YYs_i  in  C_YW  luma, unsigned.
REQ-013 UUs_i  in  C_YW  U colour difference, two's complement.
REQ-014 VVs_i  in  C_YW  V colour difference, two's complement.
REQ-015 BURST_i  in  1  1 = burst window.
REQ-016 BLANK_i  in  1  1 = blanking.
REQ-017 XSYNC_i  in  1  0 = sync tip.
REQ-018 SC_RST_i  in  1  1 = reset subcarrier phase to 0.
REQ-019 CLR_i  in  1  1 = clear OVF_o.
REQ-020 VIDEOs_o  out  C_DW  composite video code, unsigned.
REQ-021 PHASEs_o  out  2  current subcarrier phase (4fsc sample index).
REQ-022 OVF_o  out  1  sticky saturation flag.

Function
REQ-023 The 2-bit phase counter shall increment modulo 4 on each CK_i edge with CK_EE_i=1.
REQ-024 SC_RST_i=1 shall load phase 0 on the next CK_i edge regardless of CK_EE_i, taking priority over increment.
REQ-025 Stage 1 (when CK_EE_i=1) shall register Y, the control bits and the chroma sample selected by the current phase: 0:+U, 1:+V, 2:-U, 3:-V.
REQ-026 Negating -128 shall yield +128; the stage-1 chroma register shall be C_YW+1 bits signed, so no wrap occurs.
REQ-027 Stage 1 shall select burst instead of chroma when BURST_i=1: phase 0: -C_BURST_AMP, 1: 0, 2: +C_BURST_AMP, 3: 0.
REQ-028 Stage 2 shall compute Ys = (C_YGAIN*Y)>>8 and Cs = (C_CGAIN*C)>>>8 (arithmetic shift); C_BURST_AMP shall not be scaled by C_CGAIN.
REQ-029 Stage 3 shall form VIDEOs_o, with priority in this order:
  - XSYNC=0: C_SYNC_L.
  - else BLANK=1: C_PEDESTAL + burst term (burst term 0 unless BURST=1).
  - else C_PEDESTAL + Ys + Cs.
REQ-030 The stage-3 sum shall be computed signed in C_DW+3 bits, then clamped to [0, 2^C_DW-1].
REQ-031 Latency shall be 3 enabled cycles from input to VIDEOs_o; control bits shall be delayed identically to the data.
REQ-032 With CK_EE_i=0, all registers (VIDEOs_o, pipeline, phase, OVF_o) shall hold.
REQ-033 OVF_o shall set on any stage-3 clamp event; CLR_i=1 shall clear it on the next edge.
REQ-034 On simultaneous clamp and CLR_i, OVF_o shall end set.
REQ-035 CLR_i shall act regardless of CK_EE_i.
REQ-036 With C_CHROMA_EN=0, the stage-1 chroma/burst register shall be constant 0; PHASEs_o shall still count.

Reset
REQ-037 AR_i=1 shall immediately force:
  - VIDEOs_o = C_PEDESTAL, PHASEs_o = 0, OVF_o = 0;
  - all pipeline data = 0;
  - pipeline control: XSYNC = 1, BLANK = 1, BURST = 0.
REQ-038 After reset release, VIDEOs_o shall stay at C_PEDESTAL until the first valid sample reaches stage 3.
REQ-039 Reset asserted mid-line shall discard in-flight samples; no partial value shall appear.

Verification
REQ-040 Default parameters, CK_EE_i=1, Y=255, U=V=0, XSYNC=1, BLANK=0 -> VIDEOs_o = 0x379 exactly 3 cycles later.
REQ-041 Y=0, U=-128, V=0 at phases 0/1/2/3 -> VIDEOs_o = 0x070, 0x0F0, 0x170, 0x0F0; OVF_o = 0.
REQ-042 BLANK=1, BURST=1, SC_RST pulse then 4 enabled cycles -> VIDEOs_o = 0x0B8, 0x0F0, 0x128, 0x0F0; XSYNC=0 -> 0x010.
REQ-043 C_CGAIN=16'h0200, Y=255, U=+127 at phase 0 -> VIDEOs_o = 0x3FF, OVF_o = 1. Then:
  - OVF_o holds after the input returns to Y=0;
  - CLR_i pulse -> OVF_o = 0;
  - CLR_i coincident with a clamp -> OVF_o = 1.
REQ-044 CK_EE_i toggled 1/0 alternately -> latency is 3 enabled cycles, PHASEs_o advances only on enabled cycles, outputs hold otherwise.
REQ-045 AR_i asserted asynchronously mid-stream with PHASEs_o=2 -> VIDEOs_o = 0x0F0 and PHASEs_o = 0 before the next CK_i edge; OVF_o = 0.
